// File: rtl/cube_pkg.sv
// Shared definitions for the cube state loader: vector geometry, edge/corner
// slot layout, loader FSM encoding, and the solver's reference start vector.
package cube_pkg;

    localparam int STATE_W       = 120;
    localparam int NIBBLES       = STATE_W / 4;
    localparam int EDGE_LSB      = 60;
    localparam int EDGE_CNT      = 12;
    localparam int CORNER_LO_LSB = 0;
    localparam int CORNER_HI_LSB = 24;
    localparam int CORNER_CNT    = 8;

    localparam int CNT_W = 5;   // symbol counter, 0..NIBBLES
    localparam int CHK_W = 5;   // check index, covers edge + corner slots

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } ld_state_e;

    // Solver start vector: edges 3,0,1,2,4..11 in slots 0..11, corners 0..7.
    localparam logic [STATE_W-1:0] SOLVER_REF_VEC =
        120'h000BA9876542103_000000FAC000688;

    // Edge slot k lives at [EDGE_LSB+4k+3 : EDGE_LSB+4k].
    function automatic logic [3:0] edge_slot(input logic [STATE_W-1:0] vec,
                                             input logic [3:0]         slot);
        return vec[EDGE_LSB + 4*int'(slot) +: 4];
    endfunction

    // Corner slots 0..3 sit in the low word, 4..7 in the word at CORNER_HI_LSB.
    function automatic logic [2:0] corner_slot(input logic [STATE_W-1:0] vec,
                                               input logic [2:0]         slot);
        if (slot < 3'd4)
            return vec[CORNER_LO_LSB + 3*int'(slot) +: 3];
        return vec[CORNER_HI_LSB + 3*(int'(slot) - 4) +: 3];
    endfunction

endpackage

// File: rtl/perm_checker.sv
// Incremental permutation checker: one value per step, remembers which values
// have been seen, flags out-of-range or repeated values.
module perm_checker #(
    parameter int VAL_W = 4,
    parameter int N     = 12,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic [IDX_W-1:0] idx,
    input  logic [VAL_W-1:0] value,
    output logic             fail,
    output logic             last_ok
);

    // Mask spans every encodable value so an out-of-range value never indexes past it.
    localparam int M = 1 << VAL_W;

    logic [M-1:0] seen_q, seen_d;
    logic         out_of_range;

    // Evaluate the current slot and compute the updated seen mask.
    always_comb begin
        out_of_range = (int'(value) >= N);
        fail         = step && (out_of_range || seen_q[value]);
        last_ok      = step && !fail && (int'(idx) == N - 1);
        seen_d       = seen_q;
        if (clear)
            seen_d = '0;
        else if (step && !fail)
            seen_d[value] = 1'b1;
    end

    // Seen-mask register.
    always_ff @(posedge clk) begin
        if (rst)
            seen_q <= '0;
        else
            seen_q <= seen_d;
    end

endmodule

// File: rtl/cube_state_loader.sv
// Cube state loader: shifts 30 nibbles (MS nibble first) into a 120-bit vector,
// verifies the edge field is a permutation of 0..11, then raises state_valid
// and a one-cycle run_out pulse. Optional macro CUBE_CORNER_CHECK_EN extends the
// check to the eight 3-bit corner slots (must be a permutation of 0..7).
module cube_state_loader
    import cube_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [3:0]         in_data,
    output logic               in_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               state_valid,
    output logic               run_out,
    output logic               err,
    output logic               busy
);

    ld_state_e          st_q, st_d;
    logic [STATE_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CHK_W-1:0]   chk_q, chk_d;
    logic               run_q, run_d;

    logic               chk_clear;
    logic               edge_step, edge_fail, edge_last;
    logic [3:0]         edge_idx, edge_val;
    logic               check_fail, check_last;

`ifdef CUBE_CORNER_CHECK_EN
    logic               corner_step, corner_fail, corner_last;
    logic [2:0]         corner_idx, corner_val;
`endif

    // Route the slot under test to the edge (and corner) checkers.
    always_comb begin
        edge_step = (st_q == ST_CHECK) && (int'(chk_q) < EDGE_CNT);
        edge_idx  = edge_step ? chk_q[3:0] : 4'd0;
        edge_val  = edge_slot(vec_q, edge_idx);
`ifdef CUBE_CORNER_CHECK_EN
        corner_step = (st_q == ST_CHECK) && (int'(chk_q) >= EDGE_CNT);
        corner_idx  = corner_step ? 3'(int'(chk_q) - EDGE_CNT) : 3'd0;
        corner_val  = corner_slot(vec_q, corner_idx);
        check_fail  = edge_fail || corner_fail;
        check_last  = corner_last;
`else
        check_fail  = edge_fail;
        check_last  = edge_last;
`endif
    end

    perm_checker #(
        .VAL_W (4),
        .N     (EDGE_CNT),
        .IDX_W (4)
    ) u_edge_chk (
        .clk     (clk),
        .rst     (rst),
        .clear   (chk_clear),
        .step    (edge_step),
        .idx     (edge_idx),
        .value   (edge_val),
        .fail    (edge_fail),
        .last_ok (edge_last)
    );

`ifdef CUBE_CORNER_CHECK_EN
    perm_checker #(
        .VAL_W (3),
        .N     (CORNER_CNT),
        .IDX_W (3)
    ) u_corner_chk (
        .clk     (clk),
        .rst     (rst),
        .clear   (chk_clear),
        .step    (corner_step),
        .idx     (corner_idx),
        .value   (corner_val),
        .fail    (corner_fail),
        .last_ok (corner_last)
    );
`endif

    // Next-state logic: load shifting, check sequencing, run pulse generation.
    always_comb begin
        st_d      = st_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        chk_d     = chk_q;
        chk_clear = 1'b0;
        unique case (st_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    st_d      = ST_LOAD;
                    vec_d     = '0;
                    cnt_d     = '0;
                    chk_d     = '0;
                    chk_clear = 1'b1;
                end
            end
            ST_LOAD: begin
                // in_ready is high for the whole of LOAD, so in_valid alone is a handshake.
                if (in_valid) begin
                    vec_d = {vec_q[STATE_W-5:0], in_data};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (int'(cnt_q) == NIBBLES - 1) begin
                        st_d  = ST_CHECK;
                        chk_d = '0;
                    end
                end
            end
            ST_CHECK: begin
                if (check_fail)
                    st_d = ST_ERR;
                else if (check_last)
                    st_d = ST_DONE;
                else
                    chk_d = chk_q + CHK_W'(1);
            end
            default: st_d = ST_IDLE;
        endcase
        run_d = (st_q == ST_CHECK) && (st_d == ST_DONE);
    end

    // Output decode: level outputs follow the state, run_out is the registered pulse.
    always_comb begin
        in_ready    = (st_q == ST_LOAD);
        busy        = (st_q == ST_LOAD) || (st_q == ST_CHECK);
        state_valid = (st_q == ST_DONE);
        err         = (st_q == ST_ERR);
        run_out     = run_q;
        state_out   = vec_q;
    end

    // State registers; reset discards any partially loaded vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= ST_IDLE;
            vec_q <= '0;
            cnt_q <= '0;
            chk_q <= '0;
            run_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            vec_q <= vec_d;
            cnt_q <= cnt_d;
            chk_q <= chk_d;
            run_q <= run_d;
        end
    end

endmodule

// File: tb/tb_cube_state_loader.sv
// Self-checking bench for cube_state_loader: directed and randomized loads
// compared against a slot-level reference model of the permutation rules.
module tb_cube_state_loader;
    import cube_pkg::*;

    logic         clk = 1'b0;
    logic         rst, start, in_valid;
    logic [3:0]   in_data;
    logic         in_ready, state_valid, run_out, err, busy;
    logic [119:0] state_out;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef CUBE_CORNER_CHECK_EN
    localparam bit CORNER_ON = 1'b1;
`else
    localparam bit CORNER_ON = 1'b0;
`endif

    int corner_pos[8] = '{0, 3, 6, 9, 24, 27, 30, 33};

    always #5 clk = ~clk;

    cube_state_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .state_out   (state_out),
        .state_valid (state_valid),
        .run_out     (run_out),
        .err         (err),
        .busy        (busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: offset (cycles after the last handshake) at which the loader
    // reaches DONE (ok=1) or ERR (ok=0). Slot k is examined at offset 1+k.
    function automatic int model_offset(input logic [119:0] v, output bit ok);
        int e[12];
        int c[8];
        ok = 1'b0;
        for (int k = 0; k < 12; k++) e[k] = int'(v[60 + 4*k +: 4]);
        for (int k = 0; k < 12; k++) begin
            if (e[k] > 11) return 2 + k;
            for (int j = 0; j < k; j++) if (e[j] == e[k]) return 2 + k;
        end
        if (CORNER_ON) begin
            for (int k = 0; k < 8; k++) c[k] = int'(v[corner_pos[k] +: 3]);
            for (int k = 0; k < 8; k++)
                for (int j = 0; j < k; j++) if (c[j] == c[k]) return 14 + k;
            ok = 1'b1;
            return 21;
        end
        ok = 1'b1;
        return 13;
    endfunction

    function automatic logic [119:0] put_edge(input logic [119:0] v, input int k, input logic [3:0] x);
        logic [119:0] r;
        r = v;
        r[60 + 4*k +: 4] = x;
        return r;
    endfunction

    function automatic logic [119:0] put_corner(input logic [119:0] v, input int k, input logic [2:0] x);
        logic [119:0] r;
        r = v;
        r[corner_pos[k] +: 3] = x;
        return r;
    endfunction

    // mode 0: valid, 1: duplicated edge, 2: out-of-range edge, 3: duplicated corner.
    function automatic logic [119:0] rand_vec(input int mode);
        logic [119:0] v;
        int p[12];
        int q[8];
        int t, j, a, b;
        for (int i = 0; i < 4; i++) v[30*i +: 30] = 30'($urandom);
        for (int i = 0; i < 12; i++) p[i] = i;
        for (int i = 11; i > 0; i--) begin
            j = int'($urandom_range(i, 0)); t = p[i]; p[i] = p[j]; p[j] = t;
        end
        for (int i = 0; i < 8; i++) q[i] = i;
        for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(i, 0)); t = q[i]; q[i] = q[j]; q[j] = t;
        end
        for (int k = 0; k < 12; k++) v = put_edge(v, k, 4'(p[k]));
        for (int k = 0; k < 8; k++) v = put_corner(v, k, 3'(q[k]));
        a = int'($urandom_range(11, 0));
        b = (a + 1 + int'($urandom_range(10, 0))) % 12;
        case (mode)
            1: v = put_edge(v, b, 4'(p[a]));
            2: v = put_edge(v, a, 4'($urandom_range(15, 12)));
            3: v = put_corner(v, b % 8, 3'(q[a % 8 == b % 8 ? (a + 1) % 8 : a % 8]));
            default: ;
        endcase
        return v;
    endfunction

    task automatic run_load(input string tag, input logic [119:0] v, input bit gaps, input bit hold_start);
        bit ok;
        int exp_off, i, rdy_cnt, guard, runs;
        exp_off = model_offset(v, ok);
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        check_eq({tag, "/clr_err"}, err, 1'b0);
        check_eq({tag, "/clr_valid"}, state_valid, 1'b0);
        check_eq({tag, "/clr_vec"}, state_out, 0);
        check_eq({tag, "/busy_load"}, busy, 1'b1);
        i = 0; rdy_cnt = 0; guard = 0;
        while (i < 30 && guard < 2000) begin
            in_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
            in_data  = v[119 - 4*i -: 4];
            if (in_ready) rdy_cnt++;
            if (in_valid && in_ready) i++;
            guard++;
            @(negedge clk);
        end
        check_eq({tag, "/handshakes"}, i, 30);
        in_valid = 1'b0;
        start    = 1'b0;
        runs     = 0;
        for (int off = 1; off <= 24; off++) begin
            if (in_ready) rdy_cnt++;
            if (run_out) runs++;
            if (off == exp_off - 1) check_eq({tag, "/busy_chk"}, busy, 1'b1);
            if (off == exp_off) begin
                check_eq({tag, "/run_at_n"}, run_out, ok);
                check_eq({tag, "/err_at_n"}, err, !ok);
                check_eq({tag, "/valid_at_n"}, state_valid, ok);
                check_eq({tag, "/busy_end"}, busy, 1'b0);
            end
            @(negedge clk);
        end
        check_eq({tag, "/run_pulses"}, runs, ok ? 1 : 0);
        if (!gaps) check_eq({tag, "/ready_cycles"}, rdy_cnt, 30);
        check_eq({tag, "/vec"}, state_out, v);
        check_eq({tag, "/err_hold"}, err, !ok);
        check_eq({tag, "/valid_hold"}, state_valid, ok);
    endtask

    task automatic reset_mid_load(input logic [119:0] v);
        int i;
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        i = 0;
        while (i < 15) begin
            in_valid = 1'b1;
            in_data  = v[119 - 4*i -: 4];
            if (in_ready) i++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("rst/partial_vec", state_out, {60'd0, v[119:60]});
        check_eq("rst/busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst/vec", state_out, 0);
        check_eq("rst/ready", in_ready, 1'b0);
        check_eq("rst/busy", busy, 1'b0);
        check_eq("rst/valid", state_valid, 1'b0);
        check_eq("rst/run", run_out, 1'b0);
        check_eq("rst/err", err, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("rst/idle_ready", in_ready, 1'b0);
        check_eq("rst/idle_busy", busy, 1'b0);
    endtask

    initial begin
        logic [119:0] v;
        logic [2:0]   c1;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'd0;
        repeat (3) @(negedge clk);
        start = 1'b1;   // reset must win over start
        @(negedge clk);
        check_eq("reset/vec", state_out, 0);
        check_eq("reset/ready", in_ready, 1'b0);
        check_eq("reset/valid", state_valid, 1'b0);
        check_eq("reset/run", run_out, 1'b0);
        check_eq("reset/err", err, 1'b0);
        check_eq("reset/busy", busy, 1'b0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check_eq("idle/ready", in_ready, 1'b0);

        run_load("ref", SOLVER_REF_VEC, 1'b0, 1'b0);
        run_load("dup_edge", put_edge(SOLVER_REF_VEC, 0, 4'h2), 1'b0, 1'b0);
        run_load("edge5_c", put_edge(SOLVER_REF_VEC, 5, 4'hC), 1'b0, 1'b0);
        run_load("recover", SOLVER_REF_VEC, 1'b0, 1'b0);
        run_load("gaps", SOLVER_REF_VEC, 1'b1, 1'b0);
        reset_mid_load(SOLVER_REF_VEC);
        run_load("hold_start", SOLVER_REF_VEC, 1'b0, 1'b1);
        c1 = SOLVER_REF_VEC[5:3];
        run_load("corner_dup", put_corner(SOLVER_REF_VEC, 6, c1), 1'b0, 1'b0);
        run_load("last_edge_oor", put_edge(SOLVER_REF_VEC, 11, 4'hF), 1'b0, 1'b0);

        for (int t = 0; t < 16; t++) begin
            v = rand_vec(t % 4);
            run_load($sformatf("rand%0d", t), v, 1'($urandom_range(1, 0)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
